// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: load-use, branch flush and mult/div interlock.
// Optional stall/flush statistics counters are enabled with `define HAZARD_STATS_EN.
module hazard_ctrl #(
  parameter int REG_W  = 5,
  parameter int MD_LAT = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [REG_W-1:0] i_id_rs,
  input  logic [REG_W-1:0] i_id_rt,
  input  logic             i_id_use_rs,
  input  logic             i_id_use_rt,
  input  logic             i_ex_memread,
  input  logic [REG_W-1:0] i_ex_wreg,
  input  logic             i_ex_branch_taken,
  input  logic             i_id_md_start,
  input  logic             i_id_md_read,
  output logic             o_pc_stall,
  output logic             o_ifid_stall,
  output logic             o_ifid_zero,
  output logic             o_idex_zero,
  output logic             o_md_busy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]      o_stall_count,
  output logic [31:0]      o_flush_count
`endif
);

  if ((MD_LAT < 1) || (MD_LAT > 15)) begin : g_bad_md_lat
    $error("hazard_ctrl: MD_LAT must lie in 1..15");
  end

  localparam logic [3:0] MD_LAT_C = 4'(MD_LAT);

  logic [3:0] r_md_cnt;
  logic       w_lu;
  logic       w_md_busy;
  logic       w_mdh;
  logic       w_stall;
  logic       w_issue;

  // Hazard detection terms
  always_comb begin
    w_lu = i_ex_memread && (i_ex_wreg != {REG_W{1'b0}}) &&
           ((i_id_use_rs && (i_id_rs == i_ex_wreg)) ||
            (i_id_use_rt && (i_id_rt == i_ex_wreg)));
    w_md_busy = (r_md_cnt != 4'd0);
    w_mdh     = w_md_busy && (i_id_md_read || i_id_md_start);
    w_stall   = (w_lu || w_mdh) && !i_ex_branch_taken;
    w_issue   = i_id_md_start && !w_stall && !i_ex_branch_taken && !w_md_busy;
  end

  // Pipeline control outputs; a taken branch overrides any stall
  always_comb begin
    o_pc_stall   = 1'b0;
    o_ifid_stall = 1'b0;
    o_ifid_zero  = 1'b0;
    o_idex_zero  = 1'b0;
    o_md_busy    = w_md_busy;
    if (i_ex_branch_taken) begin
      o_ifid_zero = 1'b1;
      o_idex_zero = 1'b1;
    end else if (w_stall) begin
      o_pc_stall   = 1'b1;
      o_ifid_stall = 1'b1;
      o_idex_zero  = 1'b1;
    end else begin
      o_ifid_zero = 1'b0;
    end
  end

  // Mult/div busy counter; a branch flush never cancels the older in-flight op
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_md_cnt <= 4'd0;
    end else if (w_issue) begin
      r_md_cnt <= MD_LAT_C;
    end else if (r_md_cnt != 4'd0) begin
      r_md_cnt <= r_md_cnt - 4'd1;
    end else begin
      r_md_cnt <= r_md_cnt;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] r_stall_count;
  logic [31:0] r_flush_count;

  // Statistics counters, wrapping at 2^32
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_count <= 32'd0;
      r_flush_count <= 32'd0;
    end else begin
      r_stall_count <= w_stall ? (r_stall_count + 32'd1) : r_stall_count;
      r_flush_count <= i_ex_branch_taken ? (r_flush_count + 32'd1) : r_flush_count;
    end
  end

  assign o_stall_count = r_stall_count;
  assign o_flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: combinational vector table plus mult/div, branch and reset sequences.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs, id_rt, ex_wreg;
  logic       id_use_rs, id_use_rt, ex_memread, ex_branch_taken, id_md_start, id_md_read;
  logic       pc_stall, ifid_stall, ifid_zero, idex_zero, md_busy;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count, flush_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // Output vector order: {pc_stall, ifid_stall, ifid_zero, idex_zero, md_busy}
  localparam logic [4:0] IDLE = 5'b00000;
  localparam logic [4:0] BUSY = 5'b00001;
  localparam logic [4:0] STL  = 5'b11010;
  localparam logic [4:0] STLB = 5'b11011;
  localparam logic [4:0] FLS  = 5'b00110;
  localparam logic [4:0] FLSB = 5'b00111;

  hazard_ctrl #(.REG_W(5), .MD_LAT(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_id_rs(id_rs), .i_id_rt(id_rt),
    .i_id_use_rs(id_use_rs), .i_id_use_rt(id_use_rt),
    .i_ex_memread(ex_memread), .i_ex_wreg(ex_wreg),
    .i_ex_branch_taken(ex_branch_taken),
    .i_id_md_start(id_md_start), .i_id_md_read(id_md_read),
    .o_pc_stall(pc_stall), .o_ifid_stall(ifid_stall),
    .o_ifid_zero(ifid_zero), .o_idex_zero(idex_zero),
    .o_md_busy(md_busy)
`ifdef HAZARD_STATS_EN
    , .o_stall_count(stall_count), .o_flush_count(flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [4:0] rs, rt, wreg;
    logic       use_rs, use_rt, memread, br, md_read;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic clear_in();
    id_rs = 5'd0; id_rt = 5'd0; ex_wreg = 5'd0;
    id_use_rs = 1'b0; id_use_rt = 1'b0; ex_memread = 1'b0;
    ex_branch_taken = 1'b0; id_md_start = 1'b0; id_md_read = 1'b0;
  endtask

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] got;
    got = {pc_stall, ifid_stall, ifid_zero, idex_zero, md_busy};
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, got, exp);
  endtask

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  // Wait for the next negative edge, passing one rising edge, then let outputs settle
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{"idle",          5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE};
    vecs[1] = '{"lu_rs",         5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, STL};
    vecs[2] = '{"lu_r0",         5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDLE};
    vecs[3] = '{"rt_unused",     5'd0, 5'd8, 5'd8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, IDLE};
    vecs[4] = '{"lu_rt",         5'd0, 5'd8, 5'd8, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, STL};
    vecs[5] = '{"no_load",       5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, IDLE};
    vecs[6] = '{"branch_lu",     5'd8, 5'd0, 5'd8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, FLS};
    vecs[7] = '{"branch_only",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, FLS};
    vecs[8] = '{"mfhi_unit_idle",5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, IDLE};
    vecs[9] = '{"rs_mismatch",   5'd9, 5'd7, 5'd8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, IDLE};

    clear_in();
    rst = 1'b1;
    next_cycle(); next_cycle();
    #1 check("reset_state", IDLE);
    rst = 1'b0;
    next_cycle();

    for (int i = 0; i < 10; i++) begin
      clear_in();
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; ex_wreg = vecs[i].wreg;
      id_use_rs = vecs[i].use_rs; id_use_rt = vecs[i].use_rt;
      ex_memread = vecs[i].memread; ex_branch_taken = vecs[i].br;
      id_md_read = vecs[i].md_read;
      #1 check(vecs[i].name, vecs[i].exp);
      next_cycle();
    end

    // Mult issue, then mflo: counter runs 4,3,2,1 and mflo goes when it hits 0
    clear_in(); id_md_start = 1'b1;
    #1 check("md_issue", IDLE);
    next_cycle();
    clear_in();
    #1 check("md_cyc0_busy", BUSY);
    next_cycle();
    for (int c = 1; c <= 3; c++) begin
      clear_in(); id_md_read = 1'b1;
      #1 check($sformatf("mflo_stall_c%0d", c), STLB);
      next_cycle();
    end
    #1 check("mflo_proceeds", IDLE);

    // Back-to-back div: stalled while busy, issues once the counter is 0, reload to 4
    clear_in(); id_md_start = 1'b1;
    next_cycle();
    for (int c = 0; c < 4; c++) begin
      #1 check($sformatf("div_wait_c%0d", c), STLB);
      next_cycle();
    end
    #1 check("div_issues", IDLE);
    next_cycle();
    clear_in();
    #1 check("div_reload_busy", BUSY);
    next_cycle(); next_cycle();
    ex_branch_taken = 1'b1; id_md_read = 1'b1;
    #1 check("branch_over_mdh", FLSB);
    next_cycle();
    clear_in();
    #1 check("reload_last_busy", BUSY);
    next_cycle();
    #1 check("reload_done", IDLE);

    // A taken branch blocks issue of a mult in ID
    ex_branch_taken = 1'b1; id_md_start = 1'b1;
    next_cycle();
    clear_in();
    #1 check("no_issue_on_branch", IDLE);

    // Reset with md_cnt=3 clears the counter
    id_md_start = 1'b1;
    next_cycle();
    clear_in();
    next_cycle();
    #1 check("cnt3_busy", BUSY);
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    #1 check("rst_clears_cnt", IDLE);

    // Reset dominates issue
    rst = 1'b1; id_md_start = 1'b1;
    next_cycle();
    rst = 1'b0; clear_in();
    #1 check("rst_beats_issue", IDLE);

`ifdef HAZARD_STATS_EN
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    ex_memread = 1'b1; ex_wreg = 5'd8; id_rs = 5'd8; id_use_rs = 1'b1;
    next_cycle(); next_cycle(); next_cycle();
    clear_in(); ex_branch_taken = 1'b1;
    next_cycle(); next_cycle();
    clear_in();
    #1 check32("stall_count", stall_count, 32'd3);
    check32("flush_count", flush_count, 32'd2);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
